// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: steps one instruction at a time through
// FETCH/DECODE/[MEM]/EXEC/WB, gates datapath enables and counts retired instructions.
module exec_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RUN,
    input  logic                 STEP,
    input  logic                 HALT_REQ,
    input  logic                 ID_CE_ACC,
    input  logic                 ID_REG_WR,
    input  logic                 ID_CE_RAM,
    input  logic                 ID_MEM_SEL,
    input  logic                 ID_CE_PC,
    input  logic                 ID_RST_CODE,
    output logic                 CE_IR,
    output logic                 CE_ACC,
    output logic                 REG_WR,
    output logic                 CE_RAM,
    output logic                 PC_LD,
    output logic                 PC_INC,
    output logic                 PC_RST,
    output logic [2:0]           STATE,
    output logic                 HALTED,
    output logic [CNT_WIDTH-1:0] RETIRED
);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    state_t               r_state;
    logic                 r_haltPend;
    logic                 r_singleStep;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                 w_inExec;
    logic                 w_inWb;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_HALT;
            r_haltPend   <= 1'b0;
            r_singleStep <= 1'b0;
            r_retired    <= '0;
        end else begin
            // A halt request is only remembered while an instruction is in flight.
            if (HALT_REQ && (r_state != S_HALT))
                r_haltPend <= 1'b1;
            case (r_state)
                S_HALT: begin
                    if (RUN) begin
                        r_state <= S_FETCH;
                    end else if (STEP) begin
                        r_state      <= S_FETCH;
                        r_singleStep <= 1'b1;
                    end
                end
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= ID_MEM_SEL ? S_MEM : S_EXEC;
                S_MEM:    r_state <= S_EXEC;
                S_EXEC:   r_state <= S_WB;
                S_WB: begin
                    r_retired <= r_retired + ONE;
                    // HALT_REQ is checked directly so a request arriving in WB stops on this edge.
                    if (r_haltPend || HALT_REQ || r_singleStep || !RUN) begin
                        r_state      <= S_HALT;
                        r_haltPend   <= 1'b0;
                        r_singleStep <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state      <= S_HALT;
                    r_haltPend   <= 1'b0;
                    r_singleStep <= 1'b0;
                end
            endcase
        end
    end

    assign w_inExec = (r_state == S_EXEC);
    assign w_inWb   = (r_state == S_WB);

    always_comb begin
        STATE   = r_state;
        HALTED  = (r_state == S_HALT);
        CE_IR   = (r_state == S_FETCH);
        CE_ACC  = w_inExec & ID_CE_ACC;
        REG_WR  = w_inExec & ID_REG_WR;
        CE_RAM  = w_inExec & ID_CE_RAM;
        // Reset-code wins over jump so the PC controls stay mutually exclusive.
        PC_RST  = w_inWb & ID_RST_CODE;
        PC_LD   = w_inWb & ID_CE_PC & ~ID_RST_CODE;
        PC_INC  = w_inWb & ~ID_CE_PC & ~ID_RST_CODE;
        RETIRED = r_retired;
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: stimulus pushes hand-derived expectations,
// a monitor pops and compares at each sample point.
module tb_exec_sequencer;

   localparam logic [2:0] HALT   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] EXEC   = 3'd4;
   localparam logic [2:0] WB     = 3'd5;

   typedef struct packed {
      logic [2:0]  st;
      logic        ceIr;
      logic        ceAcc;
      logic        regWr;
      logic        ceRam;
      logic        pcLd;
      logic        pcInc;
      logic        pcRst;
      logic        halted;
      logic [15:0] retired;
      logic [3:0]  retired4;
   } obs_t;

   logic        clock = 1'b0;
   logic        reset, run, step, haltReq;
   logic        idCeAcc, idRegWr, idCeRam, idMemSel, idCePc, idRstCode;
   logic        ceIr, ceAcc, regWr, ceRam, pcLd, pcInc, pcRst, halted;
   logic [2:0]  state;
   logic [15:0] retired;
   logic        ceIr4, ceAcc4, regWr4, ceRam4, pcLd4, pcInc4, pcRst4, halted4;
   logic [2:0]  state4;
   logic [3:0]  retired4;

   obs_t        expQ[$];
   string       nameQ[$];
   event        chkEv;
   int          checks = 0;
   int          fails = 0;
   int          expRetired = 0;
   logic [2:0]  lastSt = HALT;

   always #5 clock = ~clock;

   exec_sequencer dut (
      .CLK(clock), .RST(reset), .RUN(run), .STEP(step), .HALT_REQ(haltReq),
      .ID_CE_ACC(idCeAcc), .ID_REG_WR(idRegWr), .ID_CE_RAM(idCeRam),
      .ID_MEM_SEL(idMemSel), .ID_CE_PC(idCePc), .ID_RST_CODE(idRstCode),
      .CE_IR(ceIr), .CE_ACC(ceAcc), .REG_WR(regWr), .CE_RAM(ceRam),
      .PC_LD(pcLd), .PC_INC(pcInc), .PC_RST(pcRst),
      .STATE(state), .HALTED(halted), .RETIRED(retired)
   );

   exec_sequencer #(.CNT_WIDTH(4)) dut4 (
      .CLK(clock), .RST(reset), .RUN(run), .STEP(step), .HALT_REQ(haltReq),
      .ID_CE_ACC(idCeAcc), .ID_REG_WR(idRegWr), .ID_CE_RAM(idCeRam),
      .ID_MEM_SEL(idMemSel), .ID_CE_PC(idCePc), .ID_RST_CODE(idRstCode),
      .CE_IR(ceIr4), .CE_ACC(ceAcc4), .REG_WR(regWr4), .CE_RAM(ceRam4),
      .PC_LD(pcLd4), .PC_INC(pcInc4), .PC_RST(pcRst4),
      .STATE(state4), .HALTED(halted4), .RETIRED(retired4)
   );

   // Expected outputs for a given state under the ID_* inputs currently driven.
   function automatic obs_t expected(input logic [2:0] st);
      obs_t o;
      logic [31:0] r;
      r          = expRetired;
      o.st       = st;
      o.ceIr     = (st == FETCH);
      o.ceAcc    = (st == EXEC) && idCeAcc;
      o.regWr    = (st == EXEC) && idRegWr;
      o.ceRam    = (st == EXEC) && idCeRam;
      o.pcRst    = (st == WB) && idRstCode;
      o.pcLd     = (st == WB) && idCePc && !idRstCode;
      o.pcInc    = (st == WB) && !idCePc && !idRstCode;
      o.halted   = (st == HALT);
      o.retired  = r[15:0];
      o.retired4 = r[3:0];
      return o;
   endfunction

   // Monitor: pops one expectation per sample point and compares, and checks
   // the structural invariants (PC controls exclusive, HALTED tracks STATE).
   always begin
      obs_t  act;
      obs_t  exp;
      string nm;
      @(negedge clock or chkEv);
      if (expQ.size() > 0) begin
         exp = expQ.pop_front();
         nm  = nameQ.pop_front();
         act = '{state, ceIr, ceAcc, regWr, ceRam, pcLd, pcInc, pcRst, halted, retired, retired4};
         checks++;
         if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual st=%0d ir=%b acc=%b rw=%b ram=%b ld=%b inc=%b rst=%b hlt=%b ret=%0d ret4=%0d, required st=%0d ir=%b acc=%b rw=%b ram=%b ld=%b inc=%b rst=%b hlt=%b ret=%0d ret4=%0d",
                     nm, act.st, act.ceIr, act.ceAcc, act.regWr, act.ceRam, act.pcLd, act.pcInc,
                     act.pcRst, act.halted, act.retired, act.retired4,
                     exp.st, exp.ceIr, exp.ceAcc, exp.regWr, exp.ceRam, exp.pcLd, exp.pcInc,
                     exp.pcRst, exp.halted, exp.retired, exp.retired4);
         end
         checks++;
         if ((int'(pcLd) + int'(pcInc) + int'(pcRst)) > 1) begin
            fails++;
            $display("[TB] FAIL %s: PC controls not exclusive ld=%b inc=%b rst=%b",
                     nm, pcLd, pcInc, pcRst);
         end
         checks++;
         if (halted !== (state == HALT)) begin
            fails++;
            $display("[TB] FAIL %s: HALTED=%b inconsistent with STATE=%0d", nm, halted, state);
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic s, input logic h);
      run     = r;
      step    = s;
      haltReq = h;
   endtask

   // ids = {ceAcc, regWr, ceRam, memSel, cePc, rstCode}
   task automatic applyIds(input logic [5:0] ids);
      {idCeAcc, idRegWr, idCeRam, idMemSel, idCePc, idRstCode} = ids;
   endtask

   // Expect the DUT to be in state st during the next clock cycle.
   task automatic checkOutput(input logic [2:0] st, input string nm);
      @(posedge clock);
      #1;
      if (lastSt == WB)
         expRetired++;
      lastSt = st;
      expQ.push_back(expected(st));
      nameQ.push_back(nm);
      @(negedge clock);
      #1;
   endtask

   // Immediate (clockless) check while reset is asserted.
   task automatic checkReset(input string nm);
      expRetired = 0;
      lastSt     = HALT;
      expQ.push_back(expected(HALT));
      nameQ.push_back(nm);
      ->chkEv;
      #1;
   endtask

   // Watchdog so a hung sequence cannot stall the run forever.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Main stimulus sequence following the verification requirements.
   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyIds(6'b000000);
      repeat (3) @(posedge clock);
      #2;
      checkReset("resetState");
      @(negedge clock);
      #1;
      reset = 1'b0;
      checkOutput(HALT, "holdAfterReset");
      checkOutput(HALT, "holdAfterReset2");

      applyStimulus(1'b1, 1'b0, 1'b0);
      applyIds(6'b111000);
      checkOutput(FETCH, "rstTestFetch");
      checkOutput(DECODE, "rstTestDecode");
      checkOutput(EXEC, "rstTestExec");
      #1;
      reset = 1'b1;
      #1;
      checkReset("rstMidExec");
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyIds(6'b000000);
      @(negedge clock);
      #1;
      reset = 1'b0;
      checkOutput(HALT, "noRetireAfterRst");

      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput(FETCH, "runFetch");
         checkOutput(DECODE, "runDecode");
         checkOutput(EXEC, "runExec");
         checkOutput(WB, "runWbInc");
      end
      checkOutput(FETCH, "runRetired3");
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput(DECODE, "runDropDecode");
      checkOutput(EXEC, "runDropExec");
      checkOutput(WB, "runDropWb");
      checkOutput(HALT, "runDropHalt");

      applyStimulus(1'b0, 1'b1, 1'b0);
      applyIds(6'b111100);
      checkOutput(FETCH, "stepFetch");
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput(DECODE, "stepDecode");
      checkOutput(MEM, "stepMem");
      checkOutput(EXEC, "stepExec");
      checkOutput(WB, "stepWb");
      checkOutput(HALT, "stepHalt");
      checkOutput(HALT, "stepStayHalt");

      applyIds(6'b000000);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput(FETCH, "hreqFetch");
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput(DECODE, "hreqDecode");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput(EXEC, "hreqExec");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput(WB, "hreqWb");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput(HALT, "hreqHalt");
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput(HALT, "hreqWhileHalted");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput(FETCH, "resumeFetch");
      checkOutput(DECODE, "resumeDecode");
      checkOutput(EXEC, "resumeExec");
      checkOutput(WB, "resumeWb");
      checkOutput(FETCH, "resumeNoStaleHalt");

      applyIds(6'b000011);
      checkOutput(DECODE, "pcRstDecode");
      checkOutput(EXEC, "pcRstExec");
      checkOutput(WB, "pcRstWb");
      checkOutput(FETCH, "pcRstNext");
      applyIds(6'b000010);
      checkOutput(DECODE, "pcLdDecode");
      checkOutput(EXEC, "pcLdExec");
      checkOutput(WB, "pcLdWb");
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput(HALT, "hreqInWb");
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyIds(6'b000000);
      checkOutput(HALT, "hreqInWbStay");

      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         checkOutput(FETCH, "wrapFetch");
         checkOutput(DECODE, "wrapDecode");
         checkOutput(EXEC, "wrapExec");
         checkOutput(WB, "wrapWb");
      end
      checkOutput(FETCH, "wrapAt16");
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput(DECODE, "wrapEndDecode");
      checkOutput(EXEC, "wrapEndExec");
      checkOutput(WB, "wrapEndWb");
      checkOutput(HALT, "wrapEndHalt");

      repeat (2) @(posedge clock);
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
